// File: rtl/bus_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// bus_arbiter_pkg
// Shared constants for the two-master / four-slave bus arbiter:
//   - FSM state encoding (IDLE, GRANT0, GRANT1)
//   - slave-select field position inside the 8-bit bus address
//   - slave index constants S0..S3 (bit positions in the one-hot select)
//   - owner encoding used by the round-robin tie breaker
//   - default and counter width for the hold limit
// ---------------------------------------------------------------------------
package bus_arbiter_pkg;

    // FSM state encoding
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_GRANT0 = 2'd1;
    localparam logic [1:0] ST_GRANT1 = 2'd2;

    // Slave-select field inside the bus address
    localparam int unsigned ADDR_SLV_MSB = 7;
    localparam int unsigned ADDR_SLV_LSB = 5;
    localparam int unsigned ADDR_SLV_W   = ADDR_SLV_MSB - ADDR_SLV_LSB + 1;

    // Slave indices (bit positions in the one-hot select vector)
    localparam int unsigned S0 = 0;
    localparam int unsigned S1 = 1;
    localparam int unsigned S2 = 2;
    localparam int unsigned S3 = 3;
    localparam int unsigned NUM_SLAVES = 4;

    // Owner encoding for last_owner
    localparam logic OWNER_M0 = 1'b0;
    localparam logic OWNER_M1 = 1'b1;

    // Hold limit: legal range 2..255, so an 8-bit counter always suffices
    localparam int unsigned MAX_HOLD_DEFAULT = 16;
    localparam int unsigned HOLD_CNT_W       = 8;

endpackage : bus_arbiter_pkg

// File: rtl/bus_addr_decoder.sv
// ---------------------------------------------------------------------------
// bus_addr_decoder
// Turns the slave-select field of the bus address (address[7:5]) into a
// one-hot slave select. Field values 000..011 select S0..S3; any value with
// the top bit set maps to no slave (valid_o = 0, sel_o = 0).
//
// Ports:
//   slv_addr_i  in  [ADDR_SLV_W-1:0]  slave-select field of the bus address
//   sel_o       out [NUM_SLAVES-1:0]  one-hot slave select (all 0 if unmapped)
//   valid_o     out                   address hits a mapped slave
// ---------------------------------------------------------------------------
module bus_addr_decoder
    import bus_arbiter_pkg::*;
(
    input  logic [ADDR_SLV_W-1:0] slv_addr_i,
    output logic [NUM_SLAVES-1:0] sel_o,
    output logic                  valid_o
);

    always_comb begin
        // NOTE: every output gets a default before the case so no path leaves
        // it unassigned; otherwise synthesis infers a latch.
        sel_o   = '0;
        valid_o = 1'b0;
        if (!slv_addr_i[ADDR_SLV_W-1]) begin
            valid_o = 1'b1;
            case (slv_addr_i[ADDR_SLV_W-2:0])
                2'd0:    sel_o[S0] = 1'b1;
                2'd1:    sel_o[S1] = 1'b1;
                2'd2:    sel_o[S2] = 1'b1;
                default: sel_o[S3] = 1'b1;
            endcase
        end
    end

endmodule : bus_addr_decoder

// File: rtl/bus_arbiter.sv
// ---------------------------------------------------------------------------
// bus_arbiter
// Two-master, four-slave bus arbiter. A three-state FSM (IDLE, GRANT0,
// GRANT1) grants the shared bus to one master; the owner's write enable,
// address and write data are routed combinationally to the slaves. The
// owner is preempted after MAX_HOLD consecutive granted cycles when the
// other master is waiting. Slave read data is returned one cycle after the
// address cycle through a registered one-hot read select.
//
// Build option:
//   ARB_ROUND_ROBIN_EN  when defined, a simultaneous request from IDLE goes
//                       to the master that did not own the bus last;
//                       otherwise M0 always wins ties.
//
// Parameters:
//   MAX_HOLD   max consecutive granted cycles while the other master waits
//              (2..255)
//
// Ports:
//   clk                      clock, all state changes on the rising edge
//   reset_n                  synchronous active-low reset
//   M0_req, M1_req           master bus requests
//   M0_wr, M1_wr             master write enables
//   M0_address, M1_address   master addresses [7:0]
//   M0_dout, M1_dout         master write data [31:0]
//   S0_dout..S3_dout         slave read data, valid one cycle after select
//   M0_grant, M1_grant       registered grants
//   S0_sel..S3_sel           slave selects
//   S_wr                     slave write enable
//   S_address                slave address [7:0]
//   S_din                    slave write data [31:0]
//   M_din                    read data returned to both masters [31:0]
// ---------------------------------------------------------------------------
module bus_arbiter
    import bus_arbiter_pkg::*;
#(
    parameter int unsigned MAX_HOLD = MAX_HOLD_DEFAULT
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        M0_req,
    input  logic        M1_req,
    input  logic        M0_wr,
    input  logic        M1_wr,
    input  logic [7:0]  M0_address,
    input  logic [7:0]  M1_address,
    input  logic [31:0] M0_dout,
    input  logic [31:0] M1_dout,
    input  logic [31:0] S0_dout,
    input  logic [31:0] S1_dout,
    input  logic [31:0] S2_dout,
    input  logic [31:0] S3_dout,
    output logic        M0_grant,
    output logic        M1_grant,
    output logic        S0_sel,
    output logic        S1_sel,
    output logic        S2_sel,
    output logic        S3_sel,
    output logic        S_wr,
    output logic [7:0]  S_address,
    output logic [31:0] S_din,
    output logic [31:0] M_din
);

    // Last value hold_cnt reaches; hitting it with the other master waiting
    // forces a switch.
    localparam logic [HOLD_CNT_W-1:0] HOLD_LAST = HOLD_CNT_W'(MAX_HOLD - 1);

    logic [1:0]            state_q,      state_d;
    logic [HOLD_CNT_W-1:0] hold_cnt_q,   hold_cnt_d;
    logic                  last_owner_q, last_owner_d;
    logic [NUM_SLAVES-1:0] rd_sel_q,     rd_sel_d;

    logic                  grant_active;
    logic                  tie_to_m1;
    logic [NUM_SLAVES-1:0] dec_sel;
    logic                  dec_valid;
    logic [NUM_SLAVES-1:0] slv_sel;

    // -----------------------------------------------------------------------
    // Tie breaking from IDLE
    // -----------------------------------------------------------------------
`ifdef ARB_ROUND_ROBIN_EN
    assign tie_to_m1 = (last_owner_q == OWNER_M0);
`else
    assign tie_to_m1 = 1'b0;
`endif

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        last_owner_d = last_owner_q;
        hold_cnt_d   = '0;

        case (state_q)
            ST_IDLE: begin
                if (M0_req && M1_req) state_d = tie_to_m1 ? ST_GRANT1 : ST_GRANT0;
                else if (M0_req)      state_d = ST_GRANT0;
                else if (M1_req)      state_d = ST_GRANT1;
            end
            ST_GRANT0: begin
                // Release hands over directly when the other master waits;
                // a full hold window forces the same handover.
                if (!M0_req)                              state_d = M1_req ? ST_GRANT1 : ST_IDLE;
                else if (M1_req && hold_cnt_q == HOLD_LAST) state_d = ST_GRANT1;
            end
            ST_GRANT1: begin
                if (!M1_req)                              state_d = M0_req ? ST_GRANT0 : ST_IDLE;
                else if (M0_req && hold_cnt_q == HOLD_LAST) state_d = ST_GRANT0;
            end
            default: state_d = ST_IDLE;
        endcase

        // hold_cnt restarts at 0 on every owner change (including entry from
        // IDLE) and saturates while the same owner keeps the bus.
        if (state_d != ST_IDLE && state_d == state_q) begin
            hold_cnt_d = (hold_cnt_q == HOLD_LAST) ? hold_cnt_q : hold_cnt_q + 1'b1;
        end

        if (state_d != state_q) begin
            if (state_d == ST_GRANT0) last_owner_d = OWNER_M0;
            if (state_d == ST_GRANT1) last_owner_d = OWNER_M1;
        end
    end

    // -----------------------------------------------------------------------
    // Bus routing from the current owner
    // -----------------------------------------------------------------------
    assign M0_grant     = (state_q == ST_GRANT0);
    assign M1_grant     = (state_q == ST_GRANT1);
    assign grant_active = M0_grant || M1_grant;

    always_comb begin
        S_wr      = 1'b0;
        S_address = '0;
        S_din     = '0;
        if (M0_grant) begin
            S_wr      = M0_wr;
            S_address = M0_address;
            S_din     = M0_dout;
        end else if (M1_grant) begin
            S_wr      = M1_wr;
            S_address = M1_address;
            S_din     = M1_dout;
        end
    end

    bus_addr_decoder u_addr_decoder (
        .slv_addr_i (S_address[ADDR_SLV_MSB:ADDR_SLV_LSB]),
        .sel_o      (dec_sel),
        .valid_o    (dec_valid)
    );

    // With no grant S_address is 0, which would decode to S0, so the
    // selects are qualified by the grant.
    assign slv_sel = (grant_active && dec_valid) ? dec_sel : '0;

    assign S0_sel = slv_sel[S0];
    assign S1_sel = slv_sel[S1];
    assign S2_sel = slv_sel[S2];
    assign S3_sel = slv_sel[S3];

    // Only read cycles remember their slave; a write or idle cycle clears it
    // so M_din drops to 0 on the following cycle.
    assign rd_sel_d = S_wr ? '0 : slv_sel;

    always_comb begin
        M_din = '0;
        if      (rd_sel_q[S0]) M_din = S0_dout;
        else if (rd_sel_q[S1]) M_din = S1_dout;
        else if (rd_sel_q[S2]) M_din = S2_dout;
        else if (rd_sel_q[S3]) M_din = S3_dout;
    end

    // -----------------------------------------------------------------------
    // State registers
    // -----------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            hold_cnt_q   <= '0;
            last_owner_q <= OWNER_M1;
            rd_sel_q     <= '0;
        end else begin
            state_q      <= state_d;
            hold_cnt_q   <= hold_cnt_d;
            last_owner_q <= last_owner_d;
            rd_sel_q     <= rd_sel_d;
        end
    end

endmodule : bus_arbiter
